// File: rtl/mem_stage_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : mem_stage_ctrl_if
// Purpose  : Single-outstanding req/ack data-memory bus used by the MEM stage.
// Revision : 1.0 - initial release
// ============================================================================
interface mem_stage_ctrl_if;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic        bus_ack;
    logic [31:0] bus_rdata;

    modport master (
        output bus_req,
        output bus_we,
        output bus_addr,
        output bus_wdata,
        input  bus_ack,
        input  bus_rdata
    );

    modport slave (
        input  bus_req,
        input  bus_we,
        input  bus_addr,
        input  bus_wdata,
        output bus_ack,
        output bus_rdata
    );
endinterface
`default_nettype wire

// File: rtl/mem_stage_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : mem_stage_ctrl
// Purpose  : MEM-stage sequencer: one load/store per instruction on a req/ack
//            bus, stalling the pipeline until the access retires or aborts.
// Revision : 1.0 - initial release
// ============================================================================
module mem_stage_ctrl #(
    parameter int TIMEOUT_CYC = 16,
    parameter int CNT_W       = 8
) (
    input  wire logic         clk,
    input  wire logic         rst_n,
    input  wire logic         mem_valid,
    input  wire logic         mem_we,
    input  wire logic [31:0]  mem_addr,
    input  wire logic [31:0]  mem_wdata,
    mem_stage_ctrl_if.master  bus,
    output logic              pipe_stall,
    output logic [31:0]       ld_data,
    output logic              ld_valid,
    output logic              bus_err,
    output logic [31:0]       err_addr
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] c_TIMEOUT_LAST = CNT_W'(TIMEOUT_CYC - 1);

    state_t            r_state,     w_state_nxt;
    logic [CNT_W-1:0]  r_cnt,       w_cnt_nxt;
    logic              r_bus_req,   w_bus_req_nxt;
    logic              r_bus_we,    w_bus_we_nxt;
    logic [31:0]       r_bus_addr,  w_bus_addr_nxt;
    logic [31:0]       r_bus_wdata, w_bus_wdata_nxt;
    logic [31:0]       r_ld_data,   w_ld_data_nxt;
    logic              r_ld_valid,  w_ld_valid_nxt;
    logic              r_bus_err,   w_bus_err_nxt;
    logic [31:0]       r_err_addr,  w_err_addr_nxt;
    logic              w_stall;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_bus_req   <= 1'b0;
            r_bus_we    <= 1'b0;
            r_bus_addr  <= '0;
            r_bus_wdata <= '0;
            r_ld_data   <= '0;
            r_ld_valid  <= 1'b0;
            r_bus_err   <= 1'b0;
            r_err_addr  <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_bus_req   <= w_bus_req_nxt;
            r_bus_we    <= w_bus_we_nxt;
            r_bus_addr  <= w_bus_addr_nxt;
            r_bus_wdata <= w_bus_wdata_nxt;
            r_ld_data   <= w_ld_data_nxt;
            r_ld_valid  <= w_ld_valid_nxt;
            r_bus_err   <= w_bus_err_nxt;
            r_err_addr  <= w_err_addr_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_cnt_nxt       = r_cnt;
        w_bus_req_nxt   = 1'b0;
        w_bus_we_nxt    = r_bus_we;
        w_bus_addr_nxt  = r_bus_addr;
        w_bus_wdata_nxt = r_bus_wdata;
        w_ld_data_nxt   = r_ld_data;
        w_ld_valid_nxt  = 1'b0;
        w_bus_err_nxt   = 1'b0;
        w_err_addr_nxt  = r_err_addr;
        w_stall         = 1'b0;

        case (r_state)
            S_IDLE: begin
                w_stall = mem_valid;
                if (mem_valid) begin
                    if (mem_addr[1:0] == 2'b00) begin
                        w_bus_req_nxt   = 1'b1;
                        w_bus_we_nxt    = mem_we;
                        w_bus_addr_nxt  = {mem_addr[31:2], 2'b00};
                        w_bus_wdata_nxt = mem_wdata;
                        w_cnt_nxt       = '0;
                        w_state_nxt     = S_REQ;
                    end else begin
                        w_bus_err_nxt  = 1'b1;
                        w_err_addr_nxt = mem_addr;
                        w_ld_data_nxt  = '0;
                        w_state_nxt    = S_DONE;
                    end
                end
            end
            S_REQ: begin
                w_stall = 1'b1;
                // ack is tested first so a last-cycle ack still completes normally
                if (bus.bus_ack) begin
                    if (!r_bus_we) begin
                        w_ld_data_nxt  = bus.bus_rdata;
                        w_ld_valid_nxt = 1'b1;
                    end
                    w_state_nxt = S_DONE;
                end else if (r_cnt == c_TIMEOUT_LAST) begin
                    w_bus_err_nxt  = 1'b1;
                    w_err_addr_nxt = r_bus_addr;
                    w_ld_data_nxt  = '0;
                    w_state_nxt    = S_DONE;
                end else begin
                    w_bus_req_nxt = 1'b1;
                    w_cnt_nxt     = r_cnt + CNT_W'(1);
                end
            end
            S_DONE: begin
                // mem_valid here still shows the retiring instruction
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign pipe_stall    = w_stall & rst_n;
    assign bus.bus_req   = r_bus_req;
    assign bus.bus_we    = r_bus_we;
    assign bus.bus_addr  = r_bus_addr;
    assign bus.bus_wdata = r_bus_wdata;
    assign ld_data       = r_ld_data;
    assign ld_valid      = r_ld_valid;
    assign bus_err       = r_bus_err;
    assign err_addr      = r_err_addr;

endmodule
`default_nettype wire

// File: doc/mem_stage_ctrl.md
Name: mem_stage_ctrl

Overview:
Sequences the MEM stage of the pipelined RISC-V core. It takes the load/store request presented by the EX/MEM pipeline register and drives a single-outstanding, variable-latency req/ack data bus. While the access is in flight, it asserts pipe_stall so the EX/MEM register and all upstream registers hold. It returns load data, flags errors (timeout, misalignment) and releases the pipeline exactly once per access.

Parameters:
TIMEOUT_CYC, 16, REQ-state cycles without bus_ack before the access is aborted (legal range 2..255)
CNT_W, 8, width of the timeout counter (must satisfy 2^CNT_W > TIMEOUT_CYC)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
mem_valid  in  1  EX/MEM holds a load or store (have_inst & (load | ram_we))
mem_we  in  1  1 = store, 0 = load
mem_addr  in  32  byte address (ALU result from EX/MEM)
mem_wdata  in  32  store data (rD2 from EX/MEM)
bus_req  out  1  request to data memory, registered
bus_we  out  1  write strobe qualifier, registered
bus_addr  out  32  word address {addr[31:2],2'b00}, registered
bus_wdata  out  32  store data, registered
bus_ack  in  1  one-cycle completion from memory
bus_rdata  in  32  read data, valid with bus_ack
pipe_stall  out  1  hold EX/MEM and upstream registers, combinational
ld_data  out  32  captured load data, registered
ld_valid  out  1  one-cycle pulse: ld_data is valid for the retiring load
bus_err  out  1  one-cycle pulse: access aborted (timeout or misaligned)
err_addr  out  32  byte address of the last errored access, sticky until the next error

Behaviour:
- Reset (async, rst_n=0): state=IDLE, counter=0. All registered outputs are 0: bus_req, bus_we, bus_addr, bus_wdata, ld_data, ld_valid, bus_err, err_addr. pipe_stall=0. Reset in any state, including mid-REQ, drops bus_req immediately. Any bus_ack for the abandoned access is ignored.
- States: IDLE, REQ, DONE.
- IDLE:
  - pipe_stall = mem_valid.
  - If mem_valid and mem_addr[1:0]==0: latch addr, wdata and we; set bus_req=1; counter=0; go to REQ.
  - If mem_valid and mem_addr[1:0]!=0 (misaligned): no bus request. Set bus_err=1, err_addr=mem_addr, ld_data=0; go to DONE.
- REQ:
  - bus_req, bus_we, bus_addr and bus_wdata are held stable. pipe_stall=1.
  - On bus_ack: bus_req=0. If it was a load, ld_data=bus_rdata and ld_valid=1. Go to DONE.
  - Without bus_ack, the counter increments. When counter==TIMEOUT_CYC-1 with no ack: bus_req=0, bus_err=1, err_addr=latched address, ld_data=0; go to DONE.
  - If ack and timeout occur in the same cycle, ack wins.
- DONE:
  - pipe_stall=0, so the pipeline advances on this edge. ld_valid or bus_err is high during this cycle only.
  - mem_valid seen in DONE belongs to the already-served instruction and is ignored. Next state is always IDLE.
- Latency: an ack in the first REQ cycle gives 3 cycles per access (IDLE-stall, REQ, DONE). Each extra wait cycle adds one.
- Non-memory instructions (mem_valid=0) never stall.
- ld_valid and bus_err are never both 1. bus_req is never high outside REQ.
- bus_ack while in IDLE or DONE is ignored.

Test Plan:
- Load, ack delayed: mem_valid=1, we=0, addr=0x0000_0104; bus_ack after 2 REQ cycles with rdata=0xDEAD_BEEF. Required: bus_addr=0x104; pipe_stall high 4 cycles; ld_valid pulses once with ld_data=0xDEAD_BEEF; bus_err=0.
- Store, immediate ack: we=1, addr=0x200, wdata=0x1234_5678; ack in the first REQ cycle. Required: bus_we=1, bus_wdata=0x1234_5678; pipe_stall high exactly 2 cycles; ld_valid=0.
- Back-to-back: load then store in consecutive instructions, both acked immediately. Required: two distinct bus_req episodes 3 cycles apart; no duplicate request in DONE.
- Timeout, TIMEOUT_CYC=16: load to 0x300 with no ack. Required: bus_req drops after 16 REQ cycles; bus_err pulses once; err_addr=0x300; ld_data=0; pipeline released.
- Misaligned: addr=0x0000_0102. Required: bus_req never asserts; bus_err pulse on the next cycle; err_addr=0x102; pipe_stall high 1 cycle.
- Reset mid-REQ: assert rst_n=0 during the 3rd wait cycle, then ack after release. Required: bus_req=0 asynchronously; state IDLE; the late ack produces no ld_valid.
